sram_axi_arbiter: RTL

- Two-master, one-slave AXI4-Lite arbiter that shares the single-port SRAM between the IFU (read-only) and the LSU (read/write).
- Sits between the two CPU-side masters and the SRAM slave port.
- Grants one complete transaction at a time and holds the grant until the response handshake finishes.
- Routes the granted master's channels through to the SRAM combinationally and blocks the other master.

---
 rtl/sram_axi_arbiter.sv | 245 ++++++++++++++++++++++++
 1 files changed

// File: rtl/sram_axi_arbiter.sv
// sram_axi_arbiter: shares the single-port SRAM (AXI4-Lite slave) between the
// IFU (read-only) and the LSU (read/write). One whole transaction is granted at
// a time and held until its response handshake completes; the granted master's
// channels are routed combinationally, the other master sees ready/valid low.
// Optional feature: define SRAM_ARB_RR_EN for round-robin arbitration on
// contention (default build: fixed priority, LSU wins).
module sram_axi_arbiter #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  // IFU master (AR/R only; AW/W/B tied off)
  input  logic                ifu_arvalid,
  output logic                ifu_arready,
  input  logic [ADDR_W-1:0]   ifu_araddr,
  input  logic [2:0]          ifu_arprot,
  output logic                ifu_rvalid,
  input  logic                ifu_rready,
  output logic [DATA_W-1:0]   ifu_rdata,
  output logic [1:0]          ifu_rresp,
  output logic                ifu_awready,
  output logic                ifu_wready,
  output logic                ifu_bvalid,
  output logic [1:0]          ifu_bresp,
  // LSU master
  input  logic                lsu_arvalid,
  output logic                lsu_arready,
  input  logic [ADDR_W-1:0]   lsu_araddr,
  input  logic [2:0]          lsu_arprot,
  output logic                lsu_rvalid,
  input  logic                lsu_rready,
  output logic [DATA_W-1:0]   lsu_rdata,
  output logic [1:0]          lsu_rresp,
  input  logic                lsu_awvalid,
  output logic                lsu_awready,
  input  logic [ADDR_W-1:0]   lsu_awaddr,
  input  logic [2:0]          lsu_awprot,
  input  logic                lsu_wvalid,
  output logic                lsu_wready,
  input  logic [DATA_W-1:0]   lsu_wdata,
  input  logic [DATA_W/8-1:0] lsu_wstrb,
  output logic                lsu_bvalid,
  input  logic                lsu_bready,
  output logic [1:0]          lsu_bresp,
  // SRAM slave
  output logic                sram_arvalid,
  input  logic                sram_arready,
  output logic [ADDR_W-1:0]   sram_araddr,
  output logic [2:0]          sram_arprot,
  input  logic                sram_rvalid,
  output logic                sram_rready,
  input  logic [DATA_W-1:0]   sram_rdata,
  input  logic [1:0]          sram_rresp,
  output logic                sram_awvalid,
  input  logic                sram_awready,
  output logic [ADDR_W-1:0]   sram_awaddr,
  output logic [2:0]          sram_awprot,
  output logic                sram_wvalid,
  input  logic                sram_wready,
  output logic [DATA_W-1:0]   sram_wdata,
  output logic [DATA_W/8-1:0] sram_wstrb,
  input  logic                sram_bvalid,
  output logic                sram_bready,
  input  logic [1:0]          sram_bresp,
  // Current owner: 00 none, 01 IFU, 10 LSU
  output logic [1:0]          grant_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_IFU_AR,
    S_IFU_R,
    S_LSU_AR,
    S_LSU_R,
    S_LSU_W,
    S_LSU_B
  } state_t;

  state_t state_q, state_d;
  logic   aw_done_q, aw_done_d;
  logic   w_done_q, w_done_d;
  logic   aw_now, w_now;

  logic   ifu_req, lsu_rd_req, lsu_wr_req, lsu_req;
  logic   lsu_wins;

  // IFU never writes
  assign ifu_awready = 1'b0;
  assign ifu_wready  = 1'b0;
  assign ifu_bvalid  = 1'b0;
  assign ifu_bresp   = 2'b00;

  assign ifu_req    = ifu_arvalid;
  assign lsu_rd_req = lsu_arvalid;
  // A write needs both address and data presented before it can be granted
  assign lsu_wr_req = lsu_awvalid & lsu_wvalid;
  assign lsu_req    = lsu_rd_req | lsu_wr_req;

`ifdef SRAM_ARB_RR_EN
  logic last_lsu_q;
  logic ifu_cpl, lsu_cpl;

  assign ifu_cpl = (state_q == S_IFU_R) & sram_rvalid & ifu_rready;
  assign lsu_cpl = ((state_q == S_LSU_R) & sram_rvalid & lsu_rready) |
                   ((state_q == S_LSU_B) & sram_bvalid & lsu_bready);

  // Remember who owned the last completed transaction (reset: IFU)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_lsu_q <= 1'b0;
    end else if (ifu_cpl) begin
      last_lsu_q <= 1'b0;
    end else if (lsu_cpl) begin
      last_lsu_q <= 1'b1;
    end
  end

  assign lsu_wins = ~last_lsu_q;
`else
  assign lsu_wins = 1'b1;
`endif

  // State and write-channel progress registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

  // Next-state decode and channel routing for the granted master
  always_comb begin
    state_d      = state_q;
    aw_done_d    = aw_done_q;
    w_done_d     = w_done_q;
    aw_now       = 1'b0;
    w_now        = 1'b0;
    grant_o      = 2'b00;
    ifu_arready  = 1'b0;
    ifu_rvalid   = 1'b0;
    ifu_rdata    = '0;
    ifu_rresp    = 2'b00;
    lsu_arready  = 1'b0;
    lsu_rvalid   = 1'b0;
    lsu_rdata    = '0;
    lsu_rresp    = 2'b00;
    lsu_awready  = 1'b0;
    lsu_wready   = 1'b0;
    lsu_bvalid   = 1'b0;
    lsu_bresp    = 2'b00;
    sram_arvalid = 1'b0;
    sram_araddr  = '0;
    sram_arprot  = 3'b000;
    sram_rready  = 1'b0;
    sram_awvalid = 1'b0;
    sram_awaddr  = '0;
    sram_awprot  = 3'b000;
    sram_wvalid  = 1'b0;
    sram_wdata   = '0;
    sram_wstrb   = '0;
    sram_bready  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (lsu_req && (lsu_wins || !ifu_req)) begin
          // Read beats write inside the LSU
          state_d = lsu_rd_req ? S_LSU_AR : S_LSU_W;
        end else if (ifu_req) begin
          state_d = S_IFU_AR;
        end
      end
      S_IFU_AR: begin
        grant_o      = 2'b01;
        sram_arvalid = ifu_arvalid;
        sram_araddr  = ifu_araddr;
        sram_arprot  = ifu_arprot;
        ifu_arready  = sram_arready;
        if (ifu_arvalid && sram_arready) state_d = S_IFU_R;
      end
      S_IFU_R: begin
        grant_o     = 2'b01;
        ifu_rvalid  = sram_rvalid;
        ifu_rdata   = sram_rdata;
        ifu_rresp   = sram_rresp;
        sram_rready = ifu_rready;
        if (sram_rvalid && ifu_rready) state_d = S_IDLE;
      end
      S_LSU_AR: begin
        grant_o      = 2'b10;
        sram_arvalid = lsu_arvalid;
        sram_araddr  = lsu_araddr;
        sram_arprot  = lsu_arprot;
        lsu_arready  = sram_arready;
        if (lsu_arvalid && sram_arready) state_d = S_LSU_R;
      end
      S_LSU_R: begin
        grant_o     = 2'b10;
        lsu_rvalid  = sram_rvalid;
        lsu_rdata   = sram_rdata;
        lsu_rresp   = sram_rresp;
        sram_rready = lsu_rready;
        if (sram_rvalid && lsu_rready) state_d = S_IDLE;
      end
      S_LSU_W: begin
        grant_o      = 2'b10;
        // A channel that already handshook is masked so it is not sent twice
        sram_awvalid = lsu_awvalid & ~aw_done_q;
        sram_awaddr  = lsu_awaddr;
        sram_awprot  = lsu_awprot;
        lsu_awready  = sram_awready & ~aw_done_q;
        sram_wvalid  = lsu_wvalid & ~w_done_q;
        sram_wdata   = lsu_wdata;
        sram_wstrb   = lsu_wstrb;
        lsu_wready   = sram_wready & ~w_done_q;
        aw_now       = aw_done_q | (sram_awvalid & sram_awready);
        w_now        = w_done_q | (sram_wvalid & sram_wready);
        if (aw_now && w_now) begin
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = S_LSU_B;
        end else begin
          aw_done_d = aw_now;
          w_done_d  = w_now;
        end
      end
      S_LSU_B: begin
        grant_o     = 2'b10;
        lsu_bvalid  = sram_bvalid;
        lsu_bresp   = sram_bresp;
        sram_bready = lsu_bready;
        if (sram_bvalid && lsu_bready) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule
